// File: rtl/gshare_branch_predictor_pkg.sv
// Shared definitions for the gshare direction predictor and its users
// (BTB, decode pipeline).
//   bp_state_e   : predictor FSM states (INIT sweeps the table, RUN predicts)
//   weak_taken() : counter reset value, 1 << (counter_bits-1)
//   ghr_width()  : physical GHR width, never narrower than one bit
package gshare_branch_predictor_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    function automatic int unsigned weak_taken(input int unsigned counter_bits);
        return 32'd1 << (counter_bits - 1);
    endfunction

    function automatic int unsigned ghr_width(input int unsigned ghr_bits);
        return (ghr_bits == 0) ? 32'd1 : ghr_bits;
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Predict/update bundle between decode, MEM and the gshare predictor.
//   master : decode/MEM side - drives predict_* requests and update_* results
//   slave  : predictor side  - drives init_busy, prediction, target, index, ghr
// INDEX_BITS : table index width; GHR_W : carried history width (>= 1)
interface gshare_branch_predictor_if #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned GHR_W      = 6
) ();

    logic                  init_busy;
    logic                  predict_valid;
    logic [31:0]           predict_pc;
    logic [31:0]           predict_offset;
    logic                  prediction;
    logic [31:0]           predict_target;
    logic [INDEX_BITS-1:0] predict_index;
    logic [GHR_W-1:0]      predict_ghr;
    logic                  update_valid;
    logic [INDEX_BITS-1:0] update_index;
    logic [GHR_W-1:0]      update_ghr;
    logic                  update_taken;
    logic                  update_mispred;

    modport master (
        input  init_busy, prediction, predict_target, predict_index, predict_ghr,
        output predict_valid, predict_pc, predict_offset,
        output update_valid, update_index, update_ghr, update_taken, update_mispred
    );

    modport slave (
        output init_busy, prediction, predict_target, predict_index, predict_ghr,
        input  predict_valid, predict_pc, predict_offset,
        input  update_valid, update_index, update_ghr, update_taken, update_mispred
    );

endinterface

// File: rtl/gshare_branch_predictor_sat_counter_table.sv
// Table of 2**DEPTH_BITS saturating counters of WIDTH bits.
//   clk          : clock
//   rd_addr_i    : asynchronous read address -> rd_data_o
//   upd_en_i     : increment/decrement the counter at upd_addr_i (saturating)
//   upd_inc_i    : 1 = count up, 0 = count down
//   init_en_i    : write the weak-taken value to init_addr_i (wins over update)
module sat_counter_table
    import gshare_branch_predictor_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = 6,
    parameter int unsigned WIDTH      = 2
) (
    input  logic                  clk,
    input  logic [DEPTH_BITS-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o,
    input  logic                  upd_en_i,
    input  logic [DEPTH_BITS-1:0] upd_addr_i,
    input  logic                  upd_inc_i,
    input  logic                  init_en_i,
    input  logic [DEPTH_BITS-1:0] init_addr_i
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_WEAK = WIDTH'(weak_taken(WIDTH));

    // No reset on the array: the INIT sweep establishes every entry.
    logic [WIDTH-1:0] mem_q [2**DEPTH_BITS];
    logic [WIDTH-1:0] upd_cur;
    logic [WIDTH-1:0] upd_d;

    // Read returns the pre-update value; no bypass from a same-cycle update.
    assign rd_data_o = mem_q[rd_addr_i];

    always_comb begin
        upd_cur = mem_q[upd_addr_i];
        upd_d   = upd_cur;
        if (upd_inc_i) begin
            if (upd_cur != CNT_MAX) upd_d = upd_cur + WIDTH'(1);
        end else begin
            if (upd_cur != '0) upd_d = upd_cur - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (init_en_i) begin
            mem_q[init_addr_i] <= CNT_WEAK;
        end else if (upd_en_i) begin
            mem_q[upd_addr_i] <= upd_d;
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare/bimodal branch direction predictor with target adder.
//   clk, rst_n : clock; asynchronous active-low reset (restarts the INIT sweep)
//   bp (slave) : predict request/response and MEM resolution bundle
//     init_busy                 high while the counter table is being swept
//     predict_valid/pc/offset   branch in decode this cycle
//     prediction/target/index/ghr  combinational response to that branch
//     update_valid/index/ghr/taken/mispred  resolved branch from MEM
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS   = 6,
    parameter int unsigned COUNTER_BITS = 2,
    parameter int unsigned GHR_BITS     = 6,
    parameter bit          GSHARE_EN    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gshare_branch_predictor_if.slave bp
);

    localparam int unsigned GHR_W = ghr_width(GHR_BITS);
    localparam bit USE_GHR = (GHR_BITS != 0) && GSHARE_EN;
    localparam logic [INDEX_BITS-1:0] PTR_LAST = '1;

    bp_state_e               state_q, state_d;
    logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
    logic [GHR_W-1:0]        ghr_q;
    logic                    run;
    logic [INDEX_BITS-1:0]   idx;
    logic [COUNTER_BITS-1:0] rd_cnt;
    logic                    prediction;

    assign run = (state_q == ST_RUN);

    // ghr_q is tied to zero when history is disabled, leaving a PC-only index.
    assign idx = bp.predict_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    assign prediction = rd_cnt[COUNTER_BITS-1] & bp.predict_valid & run;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + INDEX_BITS'(1);
                if (ptr_q == PTR_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    generate
        if (USE_GHR) begin : g_ghr
            logic [GHR_W-1:0] ghr_d;

            // Mispredict recovery outranks the speculative shift: the branch
            // predicted this cycle is younger and is being flushed.
            // The cast drops the oldest history bit off the top.
            always_comb begin
                ghr_d = ghr_q;
                if (run) begin
                    if (bp.update_valid && bp.update_mispred) begin
                        ghr_d = GHR_W'({bp.update_ghr, bp.update_taken});
                    end else if (bp.predict_valid) begin
                        ghr_d = GHR_W'({ghr_q, prediction});
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ghr_q <= '0;
                else        ghr_q <= ghr_d;
            end
        end else begin : g_no_ghr
            assign ghr_q = '0;
        end
    endgenerate

    sat_counter_table #(
        .DEPTH_BITS (INDEX_BITS),
        .WIDTH      (COUNTER_BITS)
    ) u_table (
        .clk         (clk),
        .rd_addr_i   (idx),
        .rd_data_o   (rd_cnt),
        .upd_en_i    (bp.update_valid & run),
        .upd_addr_i  (bp.update_index),
        .upd_inc_i   (bp.update_taken),
        .init_en_i   (~run),
        .init_addr_i (ptr_q)
    );

    assign bp.init_busy      = ~run;
    assign bp.prediction     = prediction;
    assign bp.predict_target = bp.predict_pc + bp.predict_offset;
    assign bp.predict_index  = idx;
    assign bp.predict_ghr    = ghr_q;

endmodule
